// File: rtl/fht_io_pkg.sv
// Shared definitions for the FHT host-side I/O sequencer: FSM encoding and
// frame-size helper.
package fht_io_pkg;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_LOAD     = 3'd1,
      S_START    = 3'd2,
      S_WAIT     = 3'd3,
      S_RD_ISSUE = 3'd4,
      S_RD_CAP   = 3'd5,
      S_EMIT     = 3'd6
   } fht_io_state_e;

   localparam int unsigned NUM_BANKS = 4;
   localparam int unsigned A_BIT_DEF = 8;

   // Points per frame: one word per bank per address.
   function automatic int unsigned fht_points(input int unsigned a_bit);
      return NUM_BANKS << a_bit;
   endfunction

endpackage

// File: rtl/fht_io_outbuf.sv
// Four-word capture buffer that serialises one bank-address row of results
// onto a valid/ready stream, flagging the final word of the frame.
module fht_io_outbuf
   import fht_io_pkg::*;
#(
   parameter int D_BIT = 17
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_capture,
   input  logic signed [D_BIT-1:0] i_data_0,
   input  logic signed [D_BIT-1:0] i_data_1,
   input  logic signed [D_BIT-1:0] i_data_2,
   input  logic signed [D_BIT-1:0] i_data_3,
   input  logic                    i_last_addr,
   input  logic                    i_m_ready,
   output logic signed [D_BIT-1:0] o_m_data,
   output logic                    o_m_valid,
   output logic                    o_m_last,
   output logic                    o_done
);

   logic signed [D_BIT-1:0] r_buf [NUM_BANKS];
   logic [1:0]              r_beat;
   logic                    r_valid;
   logic                    w_hs;

   assign w_hs      = r_valid && i_m_ready;
   assign o_m_valid = r_valid;
   assign o_m_data  = r_valid ? r_buf[r_beat] : '0;
   assign o_m_last  = r_valid && i_last_addr && (r_beat == 2'd3);
   assign o_done    = w_hs && (r_beat == 2'd3);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int k = 0; k < NUM_BANKS; k++) r_buf[k] <= '0;
         r_beat  <= 2'd0;
         r_valid <= 1'b0;
      end else if (i_capture) begin
         r_buf[0] <= i_data_0;
         r_buf[1] <= i_data_1;
         r_buf[2] <= i_data_2;
         r_buf[3] <= i_data_3;
         r_beat   <= 2'd0;
         r_valid  <= 1'b1;
      end else if (w_hs) begin
         if (r_beat == 2'd3) begin
            r_beat  <= 2'd0;
            r_valid <= 1'b0;
         end else begin
            r_beat <= r_beat + 2'd1;
         end
      end
   end

endmodule

// File: rtl/fht_io_sequencer.sv
// Host-side frame sequencer: loads N samples interleaved across the four
// RAM(A) banks, starts the FHT core, then streams the N results back out.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | waiting for the first sample of a frame
// S_LOAD     | accepting samples, writing bank n%4 at address n/4
// S_START    | one-cycle start strobe to the core
// S_WAIT     | waiting for a fresh 0->1 edge on the core ready level
// S_RD_ISSUE | read address driven, counting down the RAM read latency
// S_RD_CAP   | four bank words captured into the output buffer
// S_EMIT     | four words streamed out, then next address or back to idle
module fht_io_sequencer
   import fht_io_pkg::*;
#(
   parameter int D_BIT  = 17,
   parameter int A_BIT  = A_BIT_DEF,
   parameter int RD_LAT = 1
) (
   input  logic                    iCLK,
   input  logic                    iRESET,
   input  logic [D_BIT-2:0]        iS_DATA,
   input  logic                    iS_VALID,
   output logic                    oS_READY,
   output logic [3:0]              oFHT_WE,
   output logic [D_BIT-2:0]        oFHT_DATA,
   output logic [A_BIT-1:0]        oFHT_ADDR_WR,
   output logic [A_BIT-1:0]        oFHT_ADDR_RD,
   output logic                    oFHT_START,
   input  logic                    iFHT_RDY,
   input  logic signed [D_BIT-1:0] iFHT_DATA_0,
   input  logic signed [D_BIT-1:0] iFHT_DATA_1,
   input  logic signed [D_BIT-1:0] iFHT_DATA_2,
   input  logic signed [D_BIT-1:0] iFHT_DATA_3,
   output logic signed [D_BIT-1:0] oM_DATA,
   output logic                    oM_VALID,
   input  logic                    iM_READY,
   output logic                    oM_LAST,
   output logic                    oBUSY
);

   localparam int SMP_W = A_BIT + 2;
   localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [SMP_W-1:0] LAST_SMP = SMP_W'(fht_points(A_BIT) - 1);
   localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(RD_LAT - 1);

   fht_io_state_e    r_state;
   fht_io_state_e    w_next;
   logic [SMP_W-1:0] r_smp_cnt;
   logic [A_BIT-1:0] r_addr;
   logic [LAT_W-1:0] r_lat;
   logic             r_rdy_q;
   logic             r_armed;

   logic             w_load_st;
   logic             w_acc;
   logic             w_cap;
   logic             w_done;
   logic             w_last_addr;
   logic             w_rdy_rise;

   // Ready is gated by reset so nothing is accepted while reset is held.
   assign w_load_st    = (r_state == S_IDLE) || (r_state == S_LOAD);
   assign oS_READY     = w_load_st && !iRESET;
   assign w_acc        = iS_VALID && oS_READY;
   assign oFHT_WE      = w_acc ? (4'b0001 << r_smp_cnt[1:0]) : 4'b0000;
   assign oFHT_DATA    = w_acc ? iS_DATA : '0;
   assign oFHT_ADDR_WR = r_smp_cnt[SMP_W-1:2];
   assign oFHT_ADDR_RD = r_addr;
   assign oFHT_START   = (r_state == S_START);
   assign oBUSY        = (r_state != S_IDLE);
   assign w_last_addr  = (r_addr == '1);

   // A ready level still high from the previous transform must be seen low
   // (armed) before a rising edge counts as completion.
   assign w_rdy_rise   = r_armed && !r_rdy_q && iFHT_RDY;

   always_comb begin
      w_next = r_state;
      w_cap  = 1'b0;
      case (r_state)
         S_IDLE, S_LOAD: begin
            if (w_acc) w_next = (r_smp_cnt == LAST_SMP) ? S_START : S_LOAD;
         end
         S_START:    w_next = S_WAIT;
         S_WAIT:     if (w_rdy_rise) w_next = S_RD_ISSUE;
         S_RD_ISSUE: if (r_lat == '0) w_next = S_RD_CAP;
         S_RD_CAP: begin
            w_cap  = 1'b1;
            w_next = S_EMIT;
         end
         S_EMIT: begin
            if (w_done) w_next = w_last_addr ? S_IDLE : S_RD_ISSUE;
         end
         default:    w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge iCLK or posedge iRESET) begin
      if (iRESET) begin
         r_state   <= S_IDLE;
         r_smp_cnt <= '0;
         r_addr    <= '0;
         r_lat     <= LAT_INIT;
         r_rdy_q   <= 1'b0;
         r_armed   <= 1'b0;
      end else begin
         r_state <= w_next;

         // Sample counter parks at N-1 until the frame is fully read out.
         if (w_acc && (r_smp_cnt != LAST_SMP)) r_smp_cnt <= r_smp_cnt + 1'b1;

         if ((r_state == S_EMIT) && w_done) begin
            if (w_last_addr) begin
               r_addr    <= '0;
               r_smp_cnt <= '0;
            end else begin
               r_addr <= r_addr + 1'b1;
            end
         end

         if (r_state == S_RD_ISSUE) begin
            if (r_lat != '0) r_lat <= r_lat - 1'b1;
         end else begin
            r_lat <= LAT_INIT;
         end

         if (r_state == S_START) begin
            r_rdy_q <= 1'b0;
            r_armed <= 1'b0;
         end else begin
            r_rdy_q <= iFHT_RDY;
            if ((r_state == S_WAIT) && !iFHT_RDY) r_armed <= 1'b1;
         end
      end
   end

   fht_io_outbuf #(
      .D_BIT(D_BIT)
   ) u_outbuf (
      .i_clk       (iCLK),
      .i_rst       (iRESET),
      .i_capture   (w_cap),
      .i_data_0    (iFHT_DATA_0),
      .i_data_1    (iFHT_DATA_1),
      .i_data_2    (iFHT_DATA_2),
      .i_data_3    (iFHT_DATA_3),
      .i_last_addr (w_last_addr),
      .i_m_ready   (iM_READY),
      .o_m_data    (oM_DATA),
      .o_m_valid   (oM_VALID),
      .o_m_last    (oM_LAST),
      .o_done      (w_done)
   );

endmodule

// File: tb/tb_fht_io_sequencer.sv
// Directed bench for fht_io_sequencer with A_BIT=2 (N=16) and a simple
// one-cycle-latency bank model returning 100*bank + addr.
module tb_fht_io_sequencer;

   localparam int D_BIT  = 17;
   localparam int A_BIT  = 2;
   localparam int RD_LAT = 1;
   localparam int N      = 16;
   localparam int SW     = D_BIT - 1;

   logic                    iCLK = 1'b0;
   logic                    iRESET = 1'b1;
   logic [SW-1:0]           iS_DATA = '0;
   logic                    iS_VALID = 1'b0;
   logic                    oS_READY;
   logic [3:0]              oFHT_WE;
   logic [SW-1:0]           oFHT_DATA;
   logic [A_BIT-1:0]        oFHT_ADDR_WR;
   logic [A_BIT-1:0]        oFHT_ADDR_RD;
   logic                    oFHT_START;
   logic                    iFHT_RDY = 1'b0;
   logic signed [D_BIT-1:0] iFHT_DATA_0;
   logic signed [D_BIT-1:0] iFHT_DATA_1;
   logic signed [D_BIT-1:0] iFHT_DATA_2;
   logic signed [D_BIT-1:0] iFHT_DATA_3;
   logic signed [D_BIT-1:0] oM_DATA;
   logic                    oM_VALID;
   logic                    iM_READY = 1'b1;
   logic                    oM_LAST;
   logic                    oBUSY;

   int checks   = 0;
   int failures = 0;
   int wr_cnt   = 0;
   int start_cnt = 0;
   logic [A_BIT-1:0] addr_q = '0;

   always #5 iCLK = ~iCLK;

   fht_io_sequencer #(
      .D_BIT(D_BIT), .A_BIT(A_BIT), .RD_LAT(RD_LAT)
   ) dut (
      .iCLK(iCLK), .iRESET(iRESET),
      .iS_DATA(iS_DATA), .iS_VALID(iS_VALID), .oS_READY(oS_READY),
      .oFHT_WE(oFHT_WE), .oFHT_DATA(oFHT_DATA), .oFHT_ADDR_WR(oFHT_ADDR_WR),
      .oFHT_ADDR_RD(oFHT_ADDR_RD), .oFHT_START(oFHT_START), .iFHT_RDY(iFHT_RDY),
      .iFHT_DATA_0(iFHT_DATA_0), .iFHT_DATA_1(iFHT_DATA_1),
      .iFHT_DATA_2(iFHT_DATA_2), .iFHT_DATA_3(iFHT_DATA_3),
      .oM_DATA(oM_DATA), .oM_VALID(oM_VALID), .iM_READY(iM_READY),
      .oM_LAST(oM_LAST), .oBUSY(oBUSY)
   );

   function automatic logic signed [D_BIT-1:0] bank_word(input int k, input int a);
      return D_BIT'(100 * k + a);
   endfunction

   function automatic logic signed [D_BIT-1:0] exp_word(input int i);
      return D_BIT'(100 * (i % 4) + i / 4);
   endfunction

   function automatic logic [SW-1:0] smp(input int n);
      return SW'(n * 37 + 5);
   endfunction

   // Bank model: address registered once, so data is valid RD_LAT=1 later.
   assign iFHT_DATA_0 = bank_word(0, int'(addr_q));
   assign iFHT_DATA_1 = bank_word(1, int'(addr_q));
   assign iFHT_DATA_2 = bank_word(2, int'(addr_q));
   assign iFHT_DATA_3 = bank_word(3, int'(addr_q));

   always @(posedge iCLK) begin
      addr_q <= oFHT_ADDR_RD;
      if (oFHT_WE != 4'b0000) wr_cnt <= wr_cnt + 1;
      if (oFHT_START) start_cnt <= start_cnt + 1;
   end

   task automatic tick;
      @(posedge iCLK);
      #1;
   endtask

   task automatic test_reset;
      iS_VALID = 1'b1;
      iS_DATA  = 16'h1234;
      #3;
      checks++;
      if ({oS_READY, oFHT_WE, oFHT_START, oM_VALID, oM_LAST, oBUSY} !== 9'd0)
         begin failures++; $display("FAIL reset_init: ready=%0b we=%b start=%0b valid=%0b last=%0b busy=%0b, want all 0",
            oS_READY, oFHT_WE, oFHT_START, oM_VALID, oM_LAST, oBUSY); end
      repeat (3) tick;
      iRESET   = 1'b0;
      iS_VALID = 1'b0;
      for (int i = 0; i < 5; i++) begin
         iS_VALID = 1'b1;
         iS_DATA  = smp(i);
         tick;
      end
      #1;
      checks++;
      if (oBUSY !== 1'b1 || oFHT_ADDR_WR !== 2'd1)
         begin failures++; $display("FAIL load5: busy=%0b addr_wr=%0d, want busy=1 addr_wr=1", oBUSY, oFHT_ADDR_WR); end
      iS_DATA = 16'hBEEF;
      iRESET  = 1'b1;
      #1;
      checks++;
      if ({oS_READY, oFHT_WE, oFHT_START, oM_VALID, oM_LAST, oBUSY} !== 9'd0)
         begin failures++; $display("FAIL reset_mid_ctl: ready=%0b we=%b start=%0b valid=%0b last=%0b busy=%0b, want all 0",
            oS_READY, oFHT_WE, oFHT_START, oM_VALID, oM_LAST, oBUSY); end
      checks++;
      if (oFHT_DATA !== '0 || oFHT_ADDR_WR !== '0 || oFHT_ADDR_RD !== '0 || oM_DATA !== '0)
         begin failures++; $display("FAIL reset_mid_data: data=%0h addr_wr=%0d addr_rd=%0d m_data=%0d, want all 0",
            oFHT_DATA, oFHT_ADDR_WR, oFHT_ADDR_RD, oM_DATA); end
      tick;
      tick;
      iRESET   = 1'b0;
      iS_VALID = 1'b1;
      iS_DATA  = 16'h0ABC;
      #1;
      checks++;
      if (oS_READY !== 1'b1 || oFHT_WE !== 4'b0001 || oFHT_ADDR_WR !== 2'd0 || oFHT_DATA !== 16'h0ABC)
         begin failures++; $display("FAIL post_reset_write: ready=%0b we=%b addr_wr=%0d data=%0h, want 1 0001 0 abc",
            oS_READY, oFHT_WE, oFHT_ADDR_WR, oFHT_DATA); end
      iS_VALID = 1'b0;
   endtask

   task automatic test_load;
      int n;
      int wr0;
      int st0;
      logic v;
      n   = 0;
      wr0 = wr_cnt;
      st0 = start_cnt;
      iFHT_RDY = 1'b1;
      for (int c = 0; c < 300 && n < N; c++) begin
         tick;
         v = ($urandom_range(0, 2) != 0);
         iS_VALID = v;
         iS_DATA  = smp(n);
         #1;
         checks++;
         if (oS_READY !== 1'b1)
            begin failures++; $display("FAIL load_ready: n=%0d ready=%0b, want 1", n, oS_READY); end
         if (v) begin
            checks++;
            if (oFHT_WE !== 4'(1 << (n % 4)) || oFHT_ADDR_WR !== A_BIT'(n / 4) || oFHT_DATA !== smp(n))
               begin failures++; $display("FAIL load_map: n=%0d we=%b addr_wr=%0d data=%0h, want we=%b addr_wr=%0d data=%0h",
                  n, oFHT_WE, oFHT_ADDR_WR, oFHT_DATA, 4'(1 << (n % 4)), n / 4, smp(n)); end
            n++;
         end else begin
            checks++;
            if (oFHT_WE !== 4'b0000)
               begin failures++; $display("FAIL load_gap: we=%b, want 0000", oFHT_WE); end
         end
      end
      checks++;
      if (n != N) begin failures++; $display("FAIL load_timeout: accepted=%0d, want %0d", n, N); end
      tick;
      iS_VALID = 1'b0;
      #1;
      checks++;
      if (oFHT_START !== 1'b1 || oS_READY !== 1'b0 || oFHT_WE !== 4'b0000)
         begin failures++; $display("FAIL start_pulse: start=%0b ready=%0b we=%b, want 1 0 0000",
            oFHT_START, oS_READY, oFHT_WE); end
      tick;
      checks++;
      if (oFHT_START !== 1'b0 || oBUSY !== 1'b1)
         begin failures++; $display("FAIL start_one_cycle: start=%0b busy=%0b, want 0 1", oFHT_START, oBUSY); end
      checks++;
      if (wr_cnt - wr0 != N || start_cnt - st0 != 1)
         begin failures++; $display("FAIL write_count: writes=%0d starts=%0d, want %0d 1",
            wr_cnt - wr0, start_cnt - st0, N); end
   endtask

   task automatic test_rdy_edge;
      iM_READY = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick;
         checks++;
         if (oM_VALID !== 1'b0 || oBUSY !== 1'b1)
            begin failures++; $display("FAIL rdy_held: valid=%0b busy=%0b, want 0 1", oM_VALID, oBUSY); end
      end
      iFHT_RDY = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick;
         checks++;
         if (oM_VALID !== 1'b0)
            begin failures++; $display("FAIL rdy_low: cycle=%0d valid=%0b, want 0", i, oM_VALID); end
      end
      tick;
      iFHT_RDY = 1'b1;
      #1;
      checks++;
      if (oM_VALID !== 1'b0) begin failures++; $display("FAIL rdy_rise0: valid=%0b, want 0", oM_VALID); end
      tick;
      checks++;
      if (oM_VALID !== 1'b0 || oFHT_ADDR_RD !== 2'd0)
         begin failures++; $display("FAIL rd_issue: valid=%0b addr_rd=%0d, want 0 0", oM_VALID, oFHT_ADDR_RD); end
      tick;
      checks++;
      if (oM_VALID !== 1'b0) begin failures++; $display("FAIL rd_cap: valid=%0b, want 0", oM_VALID); end
   endtask

   task automatic test_readout;
      int idx;
      int first;
      int lastc;
      idx   = 0;
      first = -1;
      lastc = -1;
      for (int c = 0; c < 100 && idx < N; c++) begin
         tick;
         if (oM_VALID) begin
            if (first < 0) first = c;
            checks++;
            if (oM_DATA !== exp_word(idx) || oM_LAST !== (idx == N - 1))
               begin failures++; $display("FAIL readout: idx=%0d data=%0d last=%0b, want %0d %0b",
                  idx, oM_DATA, oM_LAST, exp_word(idx), (idx == N - 1)); end
            if (idx == N - 1) lastc = c;
            idx++;
         end
      end
      checks++;
      if (idx != N || first != 0 || lastc - first != 21)
         begin failures++; $display("FAIL readout_timing: words=%0d first=%0d span=%0d, want %0d 0 21",
            idx, first, lastc - first, N); end
      tick;
      checks++;
      if (oBUSY !== 1'b0 || oM_VALID !== 1'b0 || oS_READY !== 1'b1)
         begin failures++; $display("FAIL readout_end: busy=%0b valid=%0b ready=%0b, want 0 0 1",
            oBUSY, oM_VALID, oS_READY); end
   endtask

   task automatic test_backpressure;
      int idx;
      int first;
      int lastc;
      int stall;
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < N; i++) begin
         tick;
         iS_VALID = 1'b1;
         iS_DATA  = smp(i) ^ 16'h5555;
         if (oS_READY !== 1'b1) ok = 1'b0;
      end
      tick;
      iS_VALID = 1'b0;
      checks++;
      if (!ok || oFHT_START !== 1'b1)
         begin failures++; $display("FAIL frame2_load: ready_ok=%0b start=%0b, want 1 1", ok, oFHT_START); end
      tick;
      iFHT_RDY = 1'b0;
      tick;
      tick;
      iFHT_RDY = 1'b1;
      idx   = 0;
      first = -1;
      lastc = -1;
      stall = 0;
      for (int c = 0; c < 200 && idx < N; c++) begin
         tick;
         iM_READY = !(idx == 5 && stall < 7);
         if (!iM_READY) stall++;
         #1;
         if (oM_VALID) begin
            if (first < 0) first = c;
            checks++;
            if (oM_DATA !== exp_word(idx) || oM_LAST !== (idx == N - 1))
               begin failures++; $display("FAIL bp_order: idx=%0d data=%0d last=%0b, want %0d %0b",
                  idx, oM_DATA, oM_LAST, exp_word(idx), (idx == N - 1)); end
            if (!iM_READY) begin
               checks++;
               if (oFHT_ADDR_RD !== 2'd1)
                  begin failures++; $display("FAIL bp_addr_hold: addr_rd=%0d, want 1", oFHT_ADDR_RD); end
            end else begin
               if (idx == N - 1) lastc = c;
               idx++;
            end
         end
      end
      iM_READY = 1'b1;
      checks++;
      if (idx != N || stall != 7 || lastc - first != 28)
         begin failures++; $display("FAIL bp_timing: words=%0d stalls=%0d span=%0d, want %0d 7 28",
            idx, stall, lastc - first, N); end
   endtask

   task automatic test_back_to_back;
      tick;
      iS_VALID = 1'b1;
      iS_DATA  = smp(0);
      #1;
      checks++;
      if (oS_READY !== 1'b1 || oFHT_WE !== 4'b0001 || oFHT_ADDR_WR !== 2'd0 || oFHT_DATA !== smp(0))
         begin failures++; $display("FAIL b2b_accept: ready=%0b we=%b addr_wr=%0d data=%0h, want 1 0001 0 %0h",
            oS_READY, oFHT_WE, oFHT_ADDR_WR, oFHT_DATA, smp(0)); end
      tick;
      iS_VALID = 1'b0;
      #1;
      checks++;
      if (oBUSY !== 1'b1 || oFHT_WE !== 4'b0000 || oFHT_ADDR_WR !== 2'd0)
         begin failures++; $display("FAIL b2b_load: busy=%0b we=%b addr_wr=%0d, want 1 0000 0",
            oBUSY, oFHT_WE, oFHT_ADDR_WR); end
   endtask

   initial begin
      test_reset;
      test_load;
      test_rdy_edge;
      test_readout;
      test_backpressure;
      test_back_to_back;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
